// File: rtl/qsfp_link_pkg.sv
// Package for the QSFP28 link bring-up controller.
// Holds the FSM state encoding, default timing constants (125 MHz) and the
// helper that sizes the shared down-counter.
package qsfp_link_pkg;

    // Controller states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_MOD_RESET = 3'd1,
        ST_MOD_INIT  = 3'd2,
        ST_GT_RESET  = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_UP        = 3'd5
    } link_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1024;      // input stability window
    localparam int DEF_RESETL_CYCLES   = 1250;      // 10 us ResetL pulse
    localparam int DEF_INIT_CYCLES     = 250000;    // 2 ms module init wait
    localparam int DEF_GT_RST_CYCLES   = 128;       // reset_all pulse width
    localparam int DEF_LOCK_TIMEOUT    = 12500000;  // 100 ms lock wait

    // Bits needed for a counter that must hold values 0..max_count
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_signal.sv
// Multi-bit N-flop synchroniser for asynchronous level inputs.
// Each bit is synchronised independently; reset drives every stage to RST_VAL
// so the controller sees an idle/inactive input until real samples arrive.
module sync_signal #(
    parameter int               WIDTH   = 1,
    parameter int               N       = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [N];

    // Shift the raw inputs through N flops into the local clock domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[N-1];

endmodule

// File: rtl/qsfp_link_ctrl.sv
// QSFP28 cage / GT bring-up and supervision controller (125 MHz, free running).
// Debounces module presence, sequences ResetL/LPMode/ModSelL, pulses the GT
// reset_all, waits for reset-done and block lock, and re-runs the GT reset on
// sustained lock loss. Optional build macro QSFP_LINK_CTRL_STATS_EN adds a
// saturating link_down_count output counting UP->GT_RESET transitions.
module qsfp_link_ctrl
    import qsfp_link_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RESETL_CYCLES   = DEF_RESETL_CYCLES,
    parameter int INIT_CYCLES     = DEF_INIT_CYCLES,
    parameter int GT_RST_CYCLES   = DEF_GT_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
    input  logic        clk_125mhz_int,
    input  logic        gt_tx_reset,
    input  logic        qsfp_modprsl,
    input  logic        qsfp_intl,
    input  logic        rx_block_lock,
    input  logic        gt_reset_tx_done,
    input  logic        gt_reset_rx_done,
    output logic        qsfp_resetl,
    output logic        qsfp_lpmode,
    output logic        qsfp_modsell,
    output logic        gt_reset_all,
    output logic        link_up,
    output logic        int_seen,
    output logic [2:0]  state
`ifdef QSFP_LINK_CTRL_STATS_EN
    ,
    output logic [15:0] link_down_count
`endif
);

    localparam int CNT_W = cnt_width(LOCK_TIMEOUT);
    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);

    logic [4:0]       w_sync;
    logic             w_modprsl_s;
    logic             w_intl_s;
    logic             w_lock_s;
    logic             w_all_up;
    logic             r_present;
    logic [DB_W-1:0]  r_prs_cnt;
    link_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_resetl;
    logic             r_lpmode;
    logic             r_modsell;
    logic             r_gt_reset_all;
    logic             r_link_up;
    logic             r_int_seen;
`ifdef QSFP_LINK_CTRL_STATS_EN
    logic [15:0]      r_link_down_cnt;
`endif

    // Synchronise the five async inputs; modprsl/intl idle high (absent, no interrupt)
    sync_signal #(
        .WIDTH   (5),
        .N       (2),
        .RST_VAL (5'b11000)
    ) u_sync (
        .i_clk   (clk_125mhz_int),
        .i_rst   (gt_tx_reset),
        .i_async ({qsfp_modprsl, qsfp_intl, rx_block_lock, gt_reset_tx_done, gt_reset_rx_done}),
        .o_sync  (w_sync)
    );

    assign w_modprsl_s = w_sync[4];
    assign w_intl_s    = w_sync[3];
    assign w_lock_s    = w_sync[2];
    assign w_all_up    = w_sync[2] & w_sync[1] & w_sync[0];

    // Counter reload value on entry to each state (state exits when it reaches zero)
    function automatic logic [CNT_W-1:0] f_load(input link_state_t s);
        case (s)
            ST_MOD_RESET: return CNT_W'(RESETL_CYCLES - 1);
            ST_MOD_INIT:  return CNT_W'(INIT_CYCLES - 1);
            ST_GT_RESET:  return CNT_W'(GT_RST_CYCLES - 1);
            ST_WAIT_LOCK: return CNT_W'(LOCK_TIMEOUT - 1);
            ST_UP:        return CNT_W'(DEBOUNCE_CYCLES - 1);
            default:      return '0;
        endcase
    endfunction

    // Presence filter: flip only after the synced level differs for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            r_present <= 1'b0;
            r_prs_cnt <= '0;
        end else if (w_modprsl_s == r_present) begin
            if (r_prs_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_present <= ~w_modprsl_s;
                r_prs_cnt <= '0;
            end else begin
                r_prs_cnt <= r_prs_cnt + 1'b1;
            end
        end else begin
            r_prs_cnt <= '0;
        end
    end

    // Bring-up FSM with shared down-counter; outputs are decoded from the previous state
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            r_state         <= ST_ABSENT;
            r_cnt           <= '0;
            r_resetl        <= 1'b0;
            r_lpmode        <= 1'b1;
            r_modsell       <= 1'b1;
            r_gt_reset_all  <= 1'b1;
            r_link_up       <= 1'b0;
            r_int_seen      <= 1'b0;
`ifdef QSFP_LINK_CTRL_STATS_EN
            r_link_down_cnt <= '0;
`endif
        end else begin
            r_resetl       <= !(r_state == ST_ABSENT || r_state == ST_MOD_RESET);
            r_lpmode       <=  (r_state == ST_ABSENT || r_state == ST_MOD_RESET);
            r_gt_reset_all <= !(r_state == ST_WAIT_LOCK || r_state == ST_UP);
            r_modsell      <=  (r_state == ST_ABSENT);
            r_link_up      <=  (r_state == ST_UP);

            if (r_state == ST_ABSENT) begin
                r_int_seen <= 1'b0;
            end else if (!w_intl_s) begin
                r_int_seen <= 1'b1;
            end

            if (!r_present && r_state != ST_ABSENT) begin
                r_state <= ST_ABSENT;
                r_cnt   <= f_load(ST_ABSENT);
            end else begin
                case (r_state)
                    ST_ABSENT: begin
                        if (r_present) begin
                            r_state <= ST_MOD_RESET;
                            r_cnt   <= f_load(ST_MOD_RESET);
                        end
                    end
                    ST_MOD_RESET: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_MOD_INIT;
                            r_cnt   <= f_load(ST_MOD_INIT);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_MOD_INIT: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_GT_RESET;
                            r_cnt   <= f_load(ST_GT_RESET);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_GT_RESET: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_WAIT_LOCK;
                            r_cnt   <= f_load(ST_WAIT_LOCK);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_all_up) begin
                            r_state <= ST_UP;
                            r_cnt   <= f_load(ST_UP);
                        end else if (r_cnt == '0) begin
                            r_state <= ST_GT_RESET;
                            r_cnt   <= f_load(ST_GT_RESET);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_UP: begin
                        // In UP the counter is the lock-loss debounce; any lock restarts it
                        if (w_lock_s) begin
                            r_cnt <= f_load(ST_UP);
                        end else if (r_cnt == '0) begin
                            r_state <= ST_GT_RESET;
                            r_cnt   <= f_load(ST_GT_RESET);
`ifdef QSFP_LINK_CTRL_STATS_EN
                            if (r_link_down_cnt != 16'hFFFF) begin
                                r_link_down_cnt <= r_link_down_cnt + 16'd1;
                            end
`endif
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_ABSENT;
                        r_cnt   <= f_load(ST_ABSENT);
                    end
                endcase
            end
        end
    end

    assign qsfp_resetl     = r_resetl;
    assign qsfp_lpmode     = r_lpmode;
    assign qsfp_modsell    = r_modsell;
    assign gt_reset_all    = r_gt_reset_all;
    assign link_up         = r_link_up;
    assign int_seen        = r_int_seen;
    assign state           = r_state;
`ifdef QSFP_LINK_CTRL_STATS_EN
    assign link_down_count = r_link_down_cnt;
`endif

endmodule
